// File: rtl/wb_retire_queue.sv
// In-order writeback retirement buffer: queues completed MEM results, retires one per cycle,
// and flushes younger work on redirect/trap. Optional retire counter: `define WB_RETIRE_CNT_EN.
module wb_retire_queue #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 4,
    parameter int CAUSE_W = 6
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     IN_V,
    output logic                     IN_READY,
    input  logic [31:0]              IN_IR,
    input  logic [XLEN-1:0]          IN_RES,
    input  logic [XLEN-1:0]          IN_NPC,
    input  logic [XLEN-1:0]          IN_TARGET,
    input  logic                     IN_PC_MUX,
    input  logic                     IN_REG_WEN,
    input  logic                     IN_W,
    input  logic                     IN_EXC,
    input  logic [CAUSE_W-1:0]       IN_CAUSE,
    input  logic                     RETIRE_STALL,
    output logic                     OUT_DE_REG_WEN,
    output logic [4:0]               OUT_DE_DR,
    output logic [XLEN-1:0]          OUT_DE_Data,
    output logic                     OUT_FE_PC_MUX,
    output logic [XLEN-1:0]          OUT_FE_Target_Address,
    output logic                     OUT_TRAP_V,
    output logic [CAUSE_W-1:0]       OUT_TRAP_CAUSE,
    output logic [XLEN-1:0]          OUT_TRAP_PC,
    output logic                     OUT_FLUSH,
    output logic [$clog2(DEPTH):0]   OUT_COUNT
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]              RETIRE_CNT
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]         rd;
        logic [XLEN-1:0]    res;
        logic [XLEN-1:0]    npc;
        logic [XLEN-1:0]    target;
        logic               pc_mux;
        logic               reg_wen;
        logic               exc;
        logic [CAUSE_W-1:0] cause;
    } ent_t;

    ent_t          r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic          w_enq;
    logic          w_ret;
    ent_t          w_in;
    ent_t          w_head;
    logic          w_unused_ir;

    // Only rd is needed from the instruction word.
    assign w_unused_ir = ^{IN_IR[31:12], IN_IR[6:0]};

    assign IN_READY  = (r_count < FULL);
    assign OUT_COUNT = r_count;
    assign w_enq     = IN_V && IN_READY;
    assign w_ret     = (r_count != '0) && !RETIRE_STALL;
    assign w_head    = r_mem[r_head];

    // W-op zero extension is resolved at enqueue so the retire path stays short.
    always_comb begin
        w_in         = '0;
        w_in.rd      = IN_IR[11:7];
        w_in.res     = IN_W ? {{(XLEN-32){1'b0}}, IN_RES[31:0]} : IN_RES;
        w_in.npc     = IN_NPC;
        w_in.target  = IN_TARGET;
        w_in.pc_mux  = IN_PC_MUX;
        w_in.reg_wen = IN_REG_WEN;
        w_in.exc     = IN_EXC;
        w_in.cause   = IN_CAUSE;
    end

    always_ff @(posedge CLK) begin
        if (w_enq) r_mem[r_tail] <= w_in;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_head                <= '0;
            r_tail                <= '0;
            r_count               <= '0;
            OUT_DE_REG_WEN        <= 1'b0;
            OUT_DE_DR             <= '0;
            OUT_DE_Data           <= '0;
            OUT_FE_PC_MUX         <= 1'b0;
            OUT_FE_Target_Address <= '0;
            OUT_TRAP_V            <= 1'b0;
            OUT_TRAP_CAUSE        <= '0;
            OUT_TRAP_PC           <= '0;
            OUT_FLUSH             <= 1'b0;
        end else begin
            OUT_DE_REG_WEN <= 1'b0;
            OUT_FE_PC_MUX  <= 1'b0;
            OUT_TRAP_V     <= 1'b0;
            OUT_FLUSH      <= 1'b0;
            if (w_ret) begin
                if (w_head.exc) begin
                    OUT_TRAP_V     <= 1'b1;
                    OUT_TRAP_CAUSE <= w_head.cause;
                    OUT_TRAP_PC    <= w_head.npc;
                    OUT_FLUSH      <= 1'b1;
                    r_head         <= '0;
                    r_tail         <= '0;
                    r_count        <= '0;
                end else begin
                    OUT_DE_REG_WEN <= w_head.reg_wen && (w_head.rd != 5'd0);
                    OUT_DE_DR      <= w_head.rd;
                    OUT_DE_Data    <= w_head.res;
                    if (w_head.pc_mux) begin
                        // Head is the oldest, so everything else (and any new arrival) is younger.
                        OUT_FE_PC_MUX         <= 1'b1;
                        OUT_FE_Target_Address <= w_head.target;
                        OUT_FLUSH             <= 1'b1;
                        r_head                <= '0;
                        r_tail                <= '0;
                        r_count               <= '0;
                    end else begin
                        r_head <= r_head + PW'(1);
                        if (w_enq) r_tail <= r_tail + PW'(1);
                        else       r_count <= r_count - (PW+1)'(1);
                    end
                end
            end else if (w_enq) begin
                r_tail  <= r_tail + PW'(1);
                r_count <= r_count + (PW+1)'(1);
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] r_retire_cnt;
    assign RETIRE_CNT = r_retire_cnt;

    always_ff @(posedge CLK) begin
        if (RESET)                      r_retire_cnt <= '0;
        else if (w_ret && !w_head.exc)  r_retire_cnt <= r_retire_cnt + 64'd1;
    end
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed + random bench for wb_retire_queue against a queue-based retirement model.
module tb_wb_retire_queue;
    localparam int XLEN = 64, DEPTH = 4, CAUSE_W = 6;

    logic CLK = 1'b0;
    logic RESET, IN_V, IN_READY, IN_PC_MUX, IN_REG_WEN, IN_W, IN_EXC, RETIRE_STALL;
    logic [31:0] IN_IR;
    logic [XLEN-1:0] IN_RES, IN_NPC, IN_TARGET;
    logic [CAUSE_W-1:0] IN_CAUSE;
    logic OUT_DE_REG_WEN, OUT_FE_PC_MUX, OUT_TRAP_V, OUT_FLUSH;
    logic [4:0] OUT_DE_DR;
    logic [XLEN-1:0] OUT_DE_Data, OUT_FE_Target_Address, OUT_TRAP_PC;
    logic [CAUSE_W-1:0] OUT_TRAP_CAUSE;
    logic [$clog2(DEPTH):0] OUT_COUNT;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] RETIRE_CNT;
`endif

    always #5 CLK = ~CLK;

    wb_retire_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CAUSE_W(CAUSE_W)) dut (
        .CLK(CLK), .RESET(RESET), .IN_V(IN_V), .IN_READY(IN_READY), .IN_IR(IN_IR),
        .IN_RES(IN_RES), .IN_NPC(IN_NPC), .IN_TARGET(IN_TARGET), .IN_PC_MUX(IN_PC_MUX),
        .IN_REG_WEN(IN_REG_WEN), .IN_W(IN_W), .IN_EXC(IN_EXC), .IN_CAUSE(IN_CAUSE),
        .RETIRE_STALL(RETIRE_STALL), .OUT_DE_REG_WEN(OUT_DE_REG_WEN), .OUT_DE_DR(OUT_DE_DR),
        .OUT_DE_Data(OUT_DE_Data), .OUT_FE_PC_MUX(OUT_FE_PC_MUX),
        .OUT_FE_Target_Address(OUT_FE_Target_Address), .OUT_TRAP_V(OUT_TRAP_V),
        .OUT_TRAP_CAUSE(OUT_TRAP_CAUSE), .OUT_TRAP_PC(OUT_TRAP_PC), .OUT_FLUSH(OUT_FLUSH),
        .OUT_COUNT(OUT_COUNT)
`ifdef WB_RETIRE_CNT_EN
        , .RETIRE_CNT(RETIRE_CNT)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] res, npc, target;
        bit          pcm, wen, w, exc;
        logic [5:0]  cause;
    } ent_t;

    ent_t q[$];
    int total = 0, bad = 0;
    bit e_wen, e_pcm, e_trap, e_flush;
    logic [4:0] e_dr;
    logic [63:0] e_data, e_tgt, e_tpc, e_cnt;
    logic [5:0] e_cause;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [4:0] rd, input logic [63:0] res, input bit pcm,
                                input bit wen, input bit w, input bit exc, input logic [5:0] cause,
                                input logic [63:0] npc, input logic [63:0] target);
        ent_t e;
        e.rd = rd; e.res = res; e.pcm = pcm; e.wen = wen; e.w = w; e.exc = exc;
        e.cause = cause; e.npc = npc; e.target = target;
        return e;
    endfunction

    task automatic check_outputs();
        chk("reg_wen", OUT_DE_REG_WEN, e_wen);
        chk("pc_mux", OUT_FE_PC_MUX, e_pcm);
        chk("trap_v", OUT_TRAP_V, e_trap);
        chk("flush", OUT_FLUSH, e_flush);
        chk("count", OUT_COUNT, q.size());
        if (e_wen) begin
            chk("dr", OUT_DE_DR, e_dr);
            chk("data", OUT_DE_Data, e_data);
        end
        if (e_pcm) chk("target", OUT_FE_Target_Address, e_tgt);
        if (e_trap) begin
            chk("cause", OUT_TRAP_CAUSE, e_cause);
            chk("trap_pc", OUT_TRAP_PC, e_tpc);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", RETIRE_CNT, e_cnt);
`endif
    endtask

    task automatic step(input bit v, input bit stall, input ent_t e);
        logic [31:0] ir;
        ent_t h;
        bit acc;
        @(negedge CLK);
        ir = $urandom;
        ir[11:7] = e.rd;
        RESET = 1'b0; IN_V = v; RETIRE_STALL = stall; IN_IR = ir; IN_RES = e.res;
        IN_NPC = e.npc; IN_TARGET = e.target; IN_PC_MUX = e.pcm; IN_REG_WEN = e.wen;
        IN_W = e.w; IN_EXC = e.exc; IN_CAUSE = e.cause;
        #1 chk("in_ready", IN_READY, q.size() < DEPTH);
        acc = v && (q.size() < DEPTH);
        e_wen = 0; e_pcm = 0; e_trap = 0; e_flush = 0;
        if (q.size() > 0 && !stall) begin
            h = q.pop_front();
            e_flush = h.exc || h.pcm;
            if (h.exc) begin
                e_trap = 1; e_cause = h.cause; e_tpc = h.npc;
            end else begin
                e_wen = h.wen && (h.rd != 0);
                e_dr = h.rd;
                e_data = h.w ? {32'b0, h.res[31:0]} : h.res;
                e_cnt = e_cnt + 1;
                if (h.pcm) begin e_pcm = 1; e_tgt = h.target; end
            end
            if (e_flush) q.delete();
        end
        if (acc && !e_flush) q.push_back(e);
        @(posedge CLK); #1;
        check_outputs();
    endtask

    task automatic rst();
        @(negedge CLK);
        RESET = 1'b1; IN_V = 1'b1; RETIRE_STALL = 1'b0;
        @(posedge CLK); #1;
        q.delete();
        e_wen = 0; e_pcm = 0; e_trap = 0; e_flush = 0; e_cnt = 0;
        chk("rst_ready", IN_READY, 1);
        chk("rst_count", OUT_COUNT, 0);
        chk("rst_wen", OUT_DE_REG_WEN, 0);
        chk("rst_dr", OUT_DE_DR, 0);
        chk("rst_data", OUT_DE_Data, 0);
        chk("rst_pcm", OUT_FE_PC_MUX, 0);
        chk("rst_tgt", OUT_FE_Target_Address, 0);
        chk("rst_trap", OUT_TRAP_V, 0);
        chk("rst_cause", OUT_TRAP_CAUSE, 0);
        chk("rst_tpc", OUT_TRAP_PC, 0);
        chk("rst_flush", OUT_FLUSH, 0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_cnt", RETIRE_CNT, 0);
`endif
    endtask

    function automatic ent_t rnd_ent();
        return mk(5'($urandom), {$urandom, $urandom}, ($urandom % 8) == 0, $urandom % 2 == 0,
                  $urandom % 2 == 0, ($urandom % 16) == 0, 6'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom});
    endfunction

    initial begin
        ent_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        RESET = 1; IN_V = 0; RETIRE_STALL = 0; IN_IR = 0; IN_RES = 0; IN_NPC = 0;
        IN_TARGET = 0; IN_PC_MUX = 0; IN_REG_WEN = 0; IN_W = 0; IN_EXC = 0; IN_CAUSE = 0;
        rst();

        // back-to-back writes
        step(1, 0, mk(1, 64'h11, 0, 1, 0, 0, 0, 64'h0, 64'h0));
        step(1, 0, mk(2, 64'h22, 0, 1, 0, 0, 0, 64'h4, 64'h0));
        step(1, 0, mk(3, 64'h33, 0, 1, 0, 0, 0, 64'h8, 64'h0));
        step(0, 0, nop);
        step(0, 0, nop);

        // fill under stall, fifth offer ignored, then drain in order
        for (int i = 0; i < 4; i++) step(1, 1, mk(5'(4 + i), 64'(100 + i), 0, 1, 0, 0, 0, 0, 0));
        step(1, 1, mk(9, 64'hDEAD, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) step(0, 0, nop);

        // W zero-extension and rd=0 suppression
        step(1, 0, mk(5, 64'hFFFFFFFF_80000001, 0, 1, 1, 0, 0, 0, 0));
        step(1, 0, mk(0, 64'h1234, 0, 1, 0, 0, 0, 0, 0));
        step(0, 0, nop);
        step(0, 0, nop);

        // redirect with link flushes younger entries
        step(1, 1, mk(1, 64'hAA, 1, 1, 0, 0, 0, 64'h40, 64'h1000));
        step(1, 1, mk(2, 64'hBB, 0, 1, 0, 0, 0, 0, 0));
        step(1, 1, mk(3, 64'hCC, 0, 1, 0, 0, 0, 0, 0));
        step(0, 0, nop);
        step(0, 0, nop);

        // trap drops the same-edge arrival
        step(1, 1, mk(7, 64'h77, 0, 1, 0, 1, 6'd2, 64'h80, 0));
        step(1, 0, mk(8, 64'h88, 0, 1, 0, 0, 0, 0, 0));
        step(0, 0, nop);

        // reset discards queued entries and the counter
        for (int i = 0; i < 5; i++) step(1, 0, mk(5'(10 + i), 64'(i), 0, 1, 0, 0, 0, 0, 0));
        step(0, 0, nop);
        for (int i = 0; i < 3; i++) step(1, 1, mk(5'(20 + i), 64'(i), 0, 1, 0, 0, 0, 0, 0));
        rst();

        for (int i = 0; i < 400; i++) begin
            if (i == 200) rst();
            step(($urandom % 4) != 0, ($urandom % 4) == 0, rnd_ent());
        end
        for (int i = 0; i < 6; i++) step(0, 0, nop);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
